// File: rtl/mmp_iddmm_p2s.sv
// Parallel-to-serial unloader: takes one NW-word block per handshake and streams it
// out least-significant word first, one WD-bit word per accepted transfer.
module mmp_iddmm_p2s #(
  parameter int unsigned WD = 256,
  parameter int unsigned NW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [WD*NW-1:0]       ld_data,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [WD-1:0]          o_data,
  output logic [$clog2(NW)-1:0]  o_idx,
  output logic                   o_last
);

  localparam int unsigned IdxW = $clog2(NW);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q, state_d;
  logic [WD*NW-1:0]   buf_q, buf_d;
  logic [WD-1:0]      data_q, data_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic               load, xfer;

  // ld_ready reaches combinationally through o_ready so the next block can load on the
  // final word's transfer without a bubble.
  assign ld_ready = (state_q == StIdle) || (valid_q && o_ready && last_q);
  assign load     = ld_valid && ld_ready;
  assign xfer     = valid_q && o_ready;

  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_idx    = idx_q;
  assign o_last   = last_q;

  // buf_q holds the words not yet presented, shifted down so the next one sits at the bottom.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (load) begin
      buf_d   = ld_data >> WD;
      data_d  = ld_data[WD-1:0];
      idx_d   = '0;
      valid_d = 1'b1;
      last_d  = 1'b0;
      state_d = StSend;
    end else if (xfer) begin
      if (last_q) begin
        idx_d   = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        state_d = StIdle;
      end else begin
        buf_d  = buf_q >> WD;
        data_d = buf_q[WD-1:0];
        idx_d  = idx_q + 1'b1;
        last_d = (idx_q == IdxW'(NW - 2));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      buf_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_p2s.sv
// Directed self-checking bench for mmp_iddmm_p2s with WD=256, NW=16.
module tb_mmp_iddmm_p2s;

  localparam int unsigned WD = 256;
  localparam int unsigned NW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [WD*NW-1:0]     ld_data;
  logic                 o_valid;
  logic                 o_ready;
  logic [WD-1:0]        o_data;
  logic [3:0]           o_idx;
  logic                 o_last;

  int n_tests = 0;
  int n_fail  = 0;

  mmp_iddmm_p2s #(.WD(WD), .NW(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_valid (ld_valid),
    .ld_ready (ld_ready),
    .ld_data  (ld_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_idx    (o_idx),
    .o_last   (o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WD-1:0] got, input logic [WD-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WD*NW-1:0] mk_block(input int base);
    logic [WD*NW-1:0] b;
    b = '0;
    for (int k = 0; k < NW; k++) b[k*WD +: WD] = WD'(base + k);
    return b;
  endfunction

  // Present a block while idle and let it be accepted at the next edge.
  task automatic load_block(input int base);
    ld_data  = mk_block(base);
    ld_valid = 1'b1;
    #1;
    check("load_ready", WD'(ld_ready), WD'(1));
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic stream_check(input int base, input string tag);
    for (int k = 0; k < NW; k++) begin
      check({tag, "_valid"}, WD'(o_valid), WD'(1));
      check({tag, "_data"},  o_data,       WD'(base + k));
      check({tag, "_idx"},   WD'(o_idx),   WD'(k));
      check({tag, "_last"},  WD'(o_last),  WD'(k == NW - 1));
      tick();
    end
  endtask

  initial begin
    logic [31:0] pat;
    int k;
    rst_n    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = '0;
    o_ready  = 1'b0;

    // Reset / idle
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    check("rst_valid", WD'(o_valid),  WD'(0));
    check("rst_data",  o_data,        WD'(0));
    check("rst_idx",   WD'(o_idx),    WD'(0));
    check("rst_last",  WD'(o_last),   WD'(0));
    check("rst_ready", WD'(ld_ready), WD'(1));

    // Single block, o_ready held high
    o_ready = 1'b1;
    load_block(32'h1000);
    stream_check(32'h1000, "single");
    check("single_idle_valid", WD'(o_valid),  WD'(0));
    check("single_idle_ready", WD'(ld_ready), WD'(1));

    // Backpressure: fixed irregular ready pattern; every valid cycle must show word k
    pat = 32'h6B3A_94D2;
    o_ready = 1'b0;
    load_block(32'h1000);
    k = 0;
    for (int c = 0; c < 200 && k < NW; c++) begin
      o_ready = pat[c % 32];
      #1;
      check("bp_valid", WD'(o_valid), WD'(1));
      check("bp_data",  o_data,       WD'(32'h1000 + k));
      check("bp_idx",   WD'(o_idx),   WD'(k));
      if (o_ready) k++;
      tick();
    end
    check("bp_complete", WD'(k), WD'(NW));
    check("bp_idle", WD'(o_valid), WD'(0));

    // Back-to-back: B held on ld_valid while A streams
    o_ready = 1'b1;
    ld_data  = mk_block(32'hA0);
    ld_valid = 1'b1;
    tick();
    ld_data = mk_block(32'hB0);
    for (int i = 0; i < 2 * NW; i++) begin
      if (i == NW) ld_valid = 1'b0;
      #1;
      check("b2b_valid", WD'(o_valid), WD'(1));
      check("b2b_data",  o_data, (i < NW) ? WD'(32'hA0 + i) : WD'(32'hB0 + i - NW));
      if (i == 3)      check("b2b_ready_mid",  WD'(ld_ready), WD'(0));
      if (i == NW - 1) check("b2b_ready_last", WD'(ld_ready), WD'(1));
      tick();
    end
    check("b2b_idle", WD'(o_valid), WD'(0));

    // Last-word stall with a pending load
    load_block(32'hA0);
    for (int i = 0; i < NW - 1; i++) tick();
    o_ready  = 1'b0;
    ld_data  = mk_block(32'hB0);
    ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready", WD'(ld_ready), WD'(0));
      check("stall_data",  o_data,        WD'(32'hAF));
      check("stall_last",  WD'(o_last),   WD'(1));
      check("stall_valid", WD'(o_valid),  WD'(1));
      tick();
    end
    o_ready = 1'b1;
    #1;
    check("stall_release_ready", WD'(ld_ready), WD'(1));
    tick();
    ld_valid = 1'b0;
    stream_check(32'hB0, "stallB");

    // Reset mid-block
    load_block(32'h1000);
    for (int i = 0; i < 6; i++) tick();
    check("mid_pre_data", o_data, WD'(32'h1006));
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", WD'(o_valid), WD'(0));
    check("mid_rst_data",  o_data,       WD'(0));
    check("mid_rst_idx",   WD'(o_idx),   WD'(0));
    check("mid_rst_last",  WD'(o_last),  WD'(0));
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", WD'(ld_ready), WD'(1));
    load_block(32'h2000);
    stream_check(32'h2000, "post_rst");
    check("post_rst_idle", WD'(o_valid), WD'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/mmp_iddmm_p2s.md
# mmp_iddmm_p2s

Parallel-to-serial unloader for the IDDMM datapath. It accepts one full-width operand or result block of NW words of WD bits in a single handshake, then emits it least-significant word first as a WD-bit word stream under valid/ready flow control. It sits at the output of the IDDMM core, or at any point where a wide register image has to be streamed back onto the word bus. It supports back-to-back blocks at one word per cycle.

## Interface
Parameters:
- WD, 256, word width in bits
- NW, 16, words per block (NW ≥ 2; WD*NW = 4096 by default)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- ld_valid  input  1  wide block presented
- ld_ready  output  1  block can be accepted this cycle
- ld_data  input  WD*NW  block; word k = ld_data[k*WD +: WD]
- o_valid  output  1  o_data holds a valid word
- o_ready  input  1  downstream accepts the word
- o_data  output  WD  current word
- o_idx  output  clog2(NW)  index of the current word, 0..NW-1
- o_last  output  1  current word is word NW-1

## Operation
- The block has two states: IDLE and SEND. Reset enters IDLE.
- Load handshake: a load fires when ld_valid && ld_ready.
- ld_ready = (state==IDLE) || (o_valid && o_ready && o_last). This is combinational from o_ready and is intentional, to allow back-to-back blocks.
- Output handshake: a word transfers when o_valid && o_ready.
- IDLE:
  - o_valid=0.
  - On a load: capture ld_data into the NW-word buffer, set idx=0, go to SEND.
- SEND:
  - o_valid=1, o_data=buffer word idx, o_last=(idx==NW-1).
  - Transfer with idx<NW-1: idx+1, stay in SEND.
  - Transfer with idx==NW-1 and a simultaneous load: recapture buffer, idx=0, stay in SEND (no bubble).
  - Transfer with idx==NW-1 and no load: idx=0, go to IDLE.
  - No transfer: o_data, o_idx and o_last hold stable.
  - ld_data changing while in SEND is ignored except at the final-word load point.
- Implementation is free to use an indexed buffer or a right-shifting register. o_data must be a registered value, not muxed from ld_data.
- o_idx increments modulo NW and never exceeds NW-1.
- Reset (rst_n=0 at a rising edge), including mid-block:
  - in-flight block discarded; state=IDLE, idx=0
  - o_valid=0, o_data=0, o_last=0, buffer cleared to 0
  - ld_ready returns to 1 on the first cycle after reset releases.

## Timing
- Load accepted at edge N → o_valid=1 with word 0 from cycle N+1.
- With o_ready held high: word k is presented in cycle N+1+k; the block completes in NW cycles; sustained throughput is 1 word/cycle.
- Back-to-back blocks: word 0 of block B directly follows word NW-1 of block A, with no idle cycle.
- Stall: o_valid stays 1 and all outputs hold until o_ready=1 (AXI-stream-like rule). o_valid never drops without a transfer, except on reset.
- In IDLE, ld_ready does not depend on ld_valid.
- ld_ready's dependence on o_ready is the only combinational input-to-output path.

## Test plan
- Reset/idle: rst_n=0 for 3 cycles, then release → o_valid=0, o_data=0, o_idx=0, o_last=0, ld_ready=1.
- Single block, o_ready=1:
  - stimulus: load with word k = 0x1000+k (WD=256, NW=16)
  - response: 16 consecutive words 0x1000..0x100F, o_idx=0..15, o_last only on 0x100F
  - then o_valid=0 and ld_ready=1.
- Backpressure: same block with o_ready toggled by a random pattern (≈50%) → identical word order, no duplicates or drops; o_data is stable during every cycle with o_valid=1 and o_ready=0.
- Back-to-back:
  - stimulus: block A (0xA0+k), with block B (0xB0+k) held on ld_valid; o_ready=1
  - response: B is accepted in the same cycle as A's last word; 32 continuous valid words 0xA0..0xAF then 0xB0..0xBF, no gap.
- Last-word stall with a pending load: o_ready=0 on word 15 while ld_valid=1 → ld_ready=0 until o_ready=1. B must not be captured early; A's word 15 is output unchanged.
- Reset mid-block: assert rst_n=0 after word 5 of a block → outputs go to reset values at the next edge. After release, a new block 0x2000+k streams from word 0, and no stale word from the first block appears.
